// File: rtl/multi_channel_success_monitor.sv
// Multi-channel completion monitor: checks that every done channel fires once within a timeout window.
// Latency: success/fail assert one cycle after the deciding done sample; all outputs registered.
// No backpressure: done is level-sampled every RUN cycle; start is ignored while a window is running.
module multi_channel_success_monitor #(
  parameter int NUM_CHANNELS   = 4,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int CNT_WIDTH      = 8,
  parameter int STRICT         = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CHANNELS-1:0] done,
  output logic                    busy,
  output logic                    success,
  output logic                    fail,
  output logic [NUM_CHANNELS-1:0] done_mask,
  output logic [CNT_WIDTH-1:0]    cycles
);

  // Reject configurations the counter or mask cannot represent.
  generate
    if (NUM_CHANNELS < 1 || NUM_CHANNELS > 32) begin : g_bad_channels
      $error("multi_channel_success_monitor: NUM_CHANNELS must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_low
      $error("multi_channel_success_monitor: TIMEOUT_CYCLES must be at least 1");
    end
    if (64'(TIMEOUT_CYCLES) > ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_bad_timeout_high
      $error("multi_channel_success_monitor: TIMEOUT_CYCLES exceeds the cycle counter range");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] LAST_K  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0] new_mask;
  logic                    dup;

  // State, completion mask and cycle counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: duplicate beats completion, completion beats timeout on the same cycle.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    new_mask = mask_q | done;
    dup      = |(done & mask_q);
    unique case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_d = S_RUN;
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        mask_d = new_mask;
        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        if ((STRICT != 0) && dup) begin
          state_d = S_FAIL;
        end else if (&new_mask) begin
          state_d = S_PASS;
        end else if (cnt_q == LAST_K) begin
          state_d = S_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign success   = (state_q == S_PASS);
  assign fail      = (state_q == S_FAIL);
  assign done_mask = mask_q;
  assign cycles    = cnt_q;

endmodule
